// File: rtl/i2s_pkg.sv
// Shared I2S framing constants and helpers, used by both the transmit and receive stages.
package i2s_pkg;

    localparam int   SLOT_W     = 32;
    localparam int   FRAME_BITS = 64;
    localparam int   FCNT_W     = 6;
    localparam logic LR_LEFT    = 1'b0;
    localparam logic LR_RIGHT   = 1'b1;

    typedef logic [FCNT_W-1:0]     fcnt_t;
    typedef logic [FRAME_BITS-1:0] frame_t;

    // Word select runs one bit ahead of the data: it goes right on the last left bit.
    function automatic logic lr_for_fcnt(input fcnt_t f);
        return (f >= fcnt_t'(SLOT_W - 1) && f <= fcnt_t'(FRAME_BITS - 2)) ? LR_RIGHT : LR_LEFT;
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Clock generator for the I2S transmitter: MCLK = ACLK/2, BCLK = ACLK/(2*BCLK_DIV),
// plus a one-cycle strobe in the cycle BCLK is driven from 1 to 0.
module i2s_clk_gen #(
    parameter int BCLK_DIV = 4
) (
    input  logic i_aclk,
    input  logic i_arst,
    output logic o_mclk,
    output logic o_bclk,
    output logic o_bclk_fall
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    logic [DIV_W-1:0] r_div;
    logic             r_mclk;
    logic             r_bclk;
    logic             w_tc;

    assign w_tc = (r_div == DIV_W'(BCLK_DIV - 1));

    always_ff @(posedge i_aclk or posedge i_arst) begin
        if (i_arst) begin
            r_div  <= '0;
            r_mclk <= 1'b0;
            r_bclk <= 1'b0;
        end else begin
            r_mclk <= ~r_mclk;
            if (w_tc) begin
                r_div  <= '0;
                r_bclk <= ~r_bclk;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign o_mclk      = r_mclk;
    assign o_bclk      = r_bclk;
    assign o_bclk_fall = w_tc & r_bclk;

endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter: single-entry holding register on a valid/ready handshake,
// serialised MSB-first in 64-BCLK Philips frames with left-justified, zero-padded slots.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int DATA_W   = 24,
    parameter int BCLK_DIV = 4
) (
    input  logic              ACLK,
    input  logic              ARST,
    input  logic [DATA_W-1:0] DIN_L,
    input  logic [DATA_W-1:0] DIN_R,
    input  logic              DIN_VALID,
    output logic              DIN_READY,
    output logic              MCLK,
    output logic              BCLK,
    output logic              LRCLK,
    output logic              DOUT,
    output logic              UNDERRUN
);

    logic              w_fall;
    logic              w_load;
    logic              w_accept;
    fcnt_t             w_fcnt_nxt;
    frame_t            w_frame;
    logic [SLOT_W-1:0] w_slot_l;
    logic [SLOT_W-1:0] w_slot_r;

    fcnt_t             r_fcnt;
    frame_t            r_shift;
    logic [DATA_W-1:0] r_hold_l;
    logic [DATA_W-1:0] r_hold_r;
    logic              r_hold_full;
    logic              r_lrclk;
    logic              r_dout;
    logic              r_underrun;

    i2s_clk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_clk_gen (
        .i_aclk      (ACLK),
        .i_arst      (ARST),
        .o_mclk      (MCLK),
        .o_bclk      (BCLK),
        .o_bclk_fall (w_fall)
    );

    assign w_slot_l   = SLOT_W'(r_hold_l) << (SLOT_W - DATA_W);
    assign w_slot_r   = SLOT_W'(r_hold_r) << (SLOT_W - DATA_W);
    assign w_frame    = {w_slot_l, w_slot_r};
    assign w_fcnt_nxt = r_fcnt + fcnt_t'(1);
    assign w_load     = w_fall & (r_fcnt == fcnt_t'(FRAME_BITS - 1));
    assign w_accept   = DIN_VALID & ~r_hold_full;

    // FCNT starts at 63 so the very first fall after reset opens a frame.
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            r_fcnt     <= fcnt_t'(FRAME_BITS - 1);
            r_shift    <= '0;
            r_lrclk    <= LR_LEFT;
            r_dout     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (w_fall) begin
                r_fcnt  <= w_fcnt_nxt;
                r_lrclk <= lr_for_fcnt(w_fcnt_nxt);
                if (w_load) begin
                    if (r_hold_full) begin
                        r_dout  <= w_frame[FRAME_BITS-1];
                        r_shift <= w_frame << 1;
                    end else begin
                        r_dout     <= 1'b0;
                        r_shift    <= '0;
                        r_underrun <= 1'b1;
                    end
                end else begin
                    r_dout  <= r_shift[FRAME_BITS-1];
                    r_shift <= r_shift << 1;
                end
            end
        end
    end

    // Accept only happens while empty, so it can never collide with a load that drains the hold.
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            r_hold_full <= 1'b0;
            r_hold_l    <= '0;
            r_hold_r    <= '0;
        end else if (w_accept) begin
            r_hold_full <= 1'b1;
            r_hold_l    <= DIN_L;
            r_hold_r    <= DIN_R;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end
    end

    assign DIN_READY = ~r_hold_full;
    assign LRCLK     = r_lrclk;
    assign DOUT      = r_dout;
    assign UNDERRUN  = r_underrun;

endmodule
